sub_serial_32bit: RTL and testbench



---
 rtl/sub_serial_32bit_if.sv | 24 ++
 rtl/sub_serial_32bit.sv | 91 +++++++++
 tb/tb_sub_serial_32bit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sub_serial_32bit_if.sv
// Handshake and operand/result bundle for the slice-serial subtractor.
// The master drives the request and the slave returns status and results.
interface sub_serial_32bit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Dout;
  logic             Bout;
  logic             V;

  modport master (
    output start, A, B,
    input  busy, done, Dout, Bout, V
  );

  modport slave (
    input  start, A, B,
    output busy, done, Dout, Bout, V
  );
endinterface

// File: rtl/sub_serial_32bit.sv
// Slice-serial subtractor: Dout = A - B, one SLICE-bit slice per clock
// through a single reused borrow chain, with unsigned borrow-out and signed overflow.
module sub_serial_32bit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 4
) (
  input  logic              clk,
  input  logic              rst,
  sub_serial_32bit_if.slave bus
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  logic [SLICE:0]   diff_c;
  logic [WIDTH-1:0] res_next_c;

  // One slice of the borrow chain; the new slice enters at the top of the result.
  always_comb begin
    diff_c     = {1'b0, a_sh[SLICE-1:0]} - {1'b0, b_sh[SLICE-1:0]} - (SLICE+1)'(borrow);
    res_next_c = (res_sh >> SLICE) | (WIDTH'(diff_c[SLICE-1:0]) << (WIDTH - SLICE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      borrow   <= 1'b0;
      cnt      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.Dout <= '0;
      bus.Bout <= 1'b0;
      bus.V    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_sh     <= bus.A;
            b_sh     <= bus.B;
            a_msb    <= bus.A[WIDTH-1];
            b_msb    <= bus.B[WIDTH-1];
            res_sh   <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state    <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> SLICE;
          b_sh   <= b_sh >> SLICE;
          res_sh <= res_next_c;
          borrow <= diff_c[SLICE];
          if (cnt == LAST) begin
            // Final slice: publish results; they hold until the next completion.
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.Dout <= res_next_c;
            bus.Bout <= diff_c[SLICE];
            bus.V    <= (a_msb ^ b_msb) & (a_msb ^ res_next_c[WIDTH-1]);
          end else begin
            cnt      <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial_32bit.sv
// Randomized scoreboard bench for sub_serial_32bit against an arithmetic reference model.
module tb_sub_serial_32bit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned N     = 8;

  typedef struct packed {
    logic [WIDTH-1:0] dout;
    logic             bout;
    logic             v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  sub_serial_32bit_if #(.WIDTH(WIDTH)) bus ();

  sub_serial_32bit #(.WIDTH(WIDTH), .SLICE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  exp_t held;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   n_issue = 0;
  int   n_done  = 0;

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t   r;
    longint sd;
    sd     = longint'($signed(a)) - longint'($signed(b));
    r.dout = a - b;
    r.bout = (a < b);
    r.v    = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return r;
  endfunction

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      n_done++;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", {bus.Dout, bus.Bout, bus.V}, {e.dout, e.bout, e.v});
      end
    end
  end

  task automatic idle(input int n);
    bus.start = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_done", 32'(bus.done), 32'd0);
    end
  endtask

  // Issue one operation at the current negedge; returns in its DONE cycle.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit hold);
    exp_t e;
    e = model(a, b);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    q.push_back(e);
    n_issue++;
    @(posedge clk);
    for (int k = 0; k < int'(N); k++) begin
      @(negedge clk);
      chk("run_busy", 32'(bus.busy), 32'd1);
      chk("run_done", 32'(bus.done), 32'd0);
      chk("run_hold", bus.Dout, held.dout);
      bus.start = hold && (k < int'(N) - 1);
      bus.A     = $urandom;
      bus.B     = $urandom;
    end
    @(negedge clk);
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("done_pulse", 32'(bus.done), 32'd1);
    held = e;
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    held      = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_dout", bus.Dout, 32'd0);
    chk("rst_flags", {30'd0, bus.Bout, bus.V}, 32'd0);
    rst = 1'b0;

    do_op(32'd5, 32'd3, 1'b0);
    idle(1);
    do_op(32'h0000_0000, 32'h0000_0001, 1'b0);
    idle(2);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b0);
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(32'd10, 32'd10, 1'b0);
    idle(1);
    do_op(32'h1234_5678, 32'h0BAD_F00D, 1'b1);
    idle(2);

    // Abort mid-run: rst sampled at edge 4 of RUN.
    bus.start = 1'b1;
    bus.A     = 32'hDEAD_BEEF;
    bus.B     = 32'h0000_1111;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_dout", bus.Dout, 32'd0);
    chk("abort_flags", {30'd0, bus.Bout, bus.V}, 32'd0);
    rst  = 1'b0;
    held = '0;
    idle(N + 3);
    do_op($urandom, $urandom, 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_op(pick(), pick(), ($urandom_range(0, 4) == 0));
      idle($urandom_range(0, 2));
    end

    idle(3);
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("done_count", 32'(n_done), 32'(n_issue));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
